// File: rtl/console_writer_pkg.sv
// console_writer_pkg: screen geometry, control codes and shared types of the text console writer.
// The CLEAR_ALL state exists only when CONSOLE_CLEAR_EN is defined.
package console_writer_pkg;

  localparam int CONSOLE_COLS = 80;
  localparam int CONSOLE_ROWS = 30;

  typedef logic [7:0]  byte_t;
  typedef logic [11:0] vram_addr_t;

  localparam logic [4:0] LAST_ROW = 5'd29;
  localparam logic [6:0] LAST_COL = 7'd79;

  localparam byte_t CHAR_LF    = 8'h0A;
  localparam byte_t CHAR_CR    = 8'h0D;
  localparam byte_t CHAR_BS    = 8'h08;
  localparam byte_t CHAR_FF    = 8'h0C;
  localparam byte_t CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SCROLL     = 2'd1,
    ST_CLEAR_LINE = 2'd2
`ifdef CONSOLE_CLEAR_EN
    , ST_CLEAR_ALL = 2'd3
`endif
  } console_state_t;

  function automatic vram_addr_t make_addr(input logic [4:0] row, input logic [6:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/console_writer_if.sv
// console_writer_if: byte-source handshake, VRAM write/read ports and cursor taps.
// slave is the console writer side; master is the byte source / VRAM side.
interface console_writer_if;
  import console_writer_pkg::*;

  logic       char_valid_i;
  byte_t      char_data_i;
  logic       char_ready_o;
  logic       vram_we_o;
  vram_addr_t vram_waddr_o;
  byte_t      vram_wdata_o;
  vram_addr_t vram_raddr_o;
  byte_t      vram_rdata_i;
  logic [4:0] cursor_row_o;
  logic [6:0] cursor_col_o;

  modport master (
    output char_valid_i, char_data_i, vram_rdata_i,
    input  char_ready_o, vram_we_o, vram_waddr_o, vram_wdata_o, vram_raddr_o,
    input  cursor_row_o, cursor_col_o
  );

  modport slave (
    input  char_valid_i, char_data_i, vram_rdata_i,
    output char_ready_o, vram_we_o, vram_waddr_o, vram_wdata_o, vram_raddr_o,
    output cursor_row_o, cursor_col_o
  );

endinterface

// File: rtl/console_writer.sv
// console_writer: interprets a byte stream into 80x30 VRAM writes with cursor, wrap and scroll.
// Defining CONSOLE_CLEAR_EN makes 0x0C clear the whole screen; otherwise 0x0C is a glyph.
module console_writer
  import console_writer_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_i,
  console_writer_if.slave bus
);

  console_state_t r_state, w_state_next;
  logic       r_ready, w_ready_next;
  logic [4:0] r_row, w_row_next;
  logic [6:0] r_col, w_col_next;
  logic [4:0] r_cnt_row, w_cnt_row_next, w_cnt_row_inc;
  logic [6:0] r_cnt_col, w_cnt_col_next, w_cnt_col_inc;
  logic       w_cnt_last;
  logic       r_drain, w_drain_next;
  logic       r_rd_valid, w_rd_valid_next;
  vram_addr_t r_rd_dst, w_rd_dst_next;
  logic       r_we, w_we_next;
  vram_addr_t r_waddr, w_waddr_next;
  byte_t      r_wdata, w_wdata_next;
  vram_addr_t w_raddr;
  logic       w_accept, w_newline, w_clear_step;

  assign w_accept     = bus.char_valid_i & r_ready;
  // Ready follows IDLE one cycle late so it also stays low for the cycle after a busy phase ends.
  assign w_ready_next = (r_state == ST_IDLE) && (w_state_next == ST_IDLE);

  always_comb begin
    w_cnt_last = (r_cnt_row == LAST_ROW) && (r_cnt_col == LAST_COL);
    if (r_cnt_col == LAST_COL) begin
      w_cnt_col_inc = 7'd0;
      w_cnt_row_inc = r_cnt_row + 5'd1;
    end else begin
      w_cnt_col_inc = r_cnt_col + 7'd1;
      w_cnt_row_inc = r_cnt_row;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_row_next      = r_row;
    w_col_next      = r_col;
    w_cnt_row_next  = r_cnt_row;
    w_cnt_col_next  = r_cnt_col;
    w_drain_next    = 1'b0;
    w_rd_valid_next = 1'b0;
    w_rd_dst_next   = r_rd_dst;
    w_we_next       = 1'b0;
    w_waddr_next    = r_waddr;
    w_wdata_next    = r_wdata;
    w_raddr         = 12'd0;
    w_newline       = 1'b0;
    w_clear_step    = 1'b0;

    // Scroll copy data returns one cycle after its read and is written straight out.
    if (r_rd_valid) begin
      w_we_next    = 1'b1;
      w_waddr_next = r_rd_dst;
      w_wdata_next = bus.vram_rdata_i;
    end else begin
      w_we_next    = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (bus.char_data_i == CHAR_LF) begin
            w_col_next = 7'd0;
            w_newline  = 1'b1;
          end else if (bus.char_data_i == CHAR_CR) begin
            w_col_next = 7'd0;
          end else if (bus.char_data_i == CHAR_BS) begin
            if (r_col != 7'd0) begin
              w_col_next   = r_col - 7'd1;
              w_we_next    = 1'b1;
              w_waddr_next = make_addr(r_row, r_col - 7'd1);
              w_wdata_next = CHAR_SPACE;
            end else begin
              w_col_next   = r_col;
            end
`ifdef CONSOLE_CLEAR_EN
          end else if (bus.char_data_i == CHAR_FF) begin
            w_state_next   = ST_CLEAR_ALL;
            w_row_next     = 5'd0;
            w_col_next     = 7'd0;
            w_cnt_row_next = 5'd0;
            w_cnt_col_next = 7'd0;
`endif
          end else begin
            w_we_next    = 1'b1;
            w_waddr_next = make_addr(r_row, r_col);
            w_wdata_next = bus.char_data_i;
            if (r_col == LAST_COL) begin
              w_col_next = 7'd0;
              w_newline  = 1'b1;
            end else begin
              w_col_next = r_col + 7'd1;
            end
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SCROLL: begin
        // One drain cycle after the last read lets its copy write leave before clearing starts.
        if (r_drain) begin
          w_state_next   = ST_CLEAR_LINE;
          w_cnt_row_next = LAST_ROW;
          w_cnt_col_next = 7'd0;
        end else begin
          w_raddr         = make_addr(r_cnt_row, r_cnt_col);
          w_rd_valid_next = 1'b1;
          w_rd_dst_next   = make_addr(r_cnt_row - 5'd1, r_cnt_col);
          w_drain_next    = w_cnt_last;
          w_cnt_row_next  = w_cnt_row_inc;
          w_cnt_col_next  = w_cnt_col_inc;
        end
      end
      ST_CLEAR_LINE: w_clear_step = 1'b1;
`ifdef CONSOLE_CLEAR_EN
      ST_CLEAR_ALL:  w_clear_step = 1'b1;
`endif
      default:       w_state_next = ST_IDLE;
    endcase

    if (w_newline) begin
      if (r_row == LAST_ROW) begin
        w_state_next   = ST_SCROLL;
        w_cnt_row_next = 5'd1;
        w_cnt_col_next = 7'd0;
      end else begin
        w_row_next     = r_row + 5'd1;
      end
    end else begin
      w_row_next = w_row_next;
    end

    if (w_clear_step) begin
      w_we_next    = 1'b1;
      w_waddr_next = make_addr(r_cnt_row, r_cnt_col);
      w_wdata_next = CHAR_SPACE;
      if (w_cnt_last) begin
        w_state_next = ST_IDLE;
      end else begin
        w_cnt_row_next = w_cnt_row_inc;
        w_cnt_col_next = w_cnt_col_inc;
      end
    end else begin
      w_clear_step = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b0;
      r_row      <= 5'd0;
      r_col      <= 7'd0;
      r_cnt_row  <= 5'd0;
      r_cnt_col  <= 7'd0;
      r_drain    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_dst   <= 12'd0;
      r_we       <= 1'b0;
      r_waddr    <= 12'd0;
      r_wdata    <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_ready    <= w_ready_next;
      r_row      <= w_row_next;
      r_col      <= w_col_next;
      r_cnt_row  <= w_cnt_row_next;
      r_cnt_col  <= w_cnt_col_next;
      r_drain    <= w_drain_next;
      r_rd_valid <= w_rd_valid_next;
      r_rd_dst   <= w_rd_dst_next;
      r_we       <= w_we_next;
      r_waddr    <= w_waddr_next;
      r_wdata    <= w_wdata_next;
    end
  end

  assign bus.char_ready_o = r_ready;
  assign bus.vram_we_o    = r_we;
  assign bus.vram_waddr_o = r_waddr;
  assign bus.vram_wdata_o = r_wdata;
  assign bus.vram_raddr_o = w_raddr;
  assign bus.cursor_row_o = r_row;
  assign bus.cursor_col_o = r_col;

endmodule

// File: doc/console_writer.md
# console_writer

Text-mode console writer: the producer side of the 80×30 character VRAM that the VGA scan-out reads. Accepts a byte stream (CPU MMIO or UART), interprets control codes, writes glyph codes at a hardware cursor, and wraps lines. At the bottom row it scrolls the screen by copying rows up through a second VRAM port. Sits between the byte source and the VRAM write/read ports; VRAM address is {row[4:0], col[6:0]}.

## Interface
- No parameters. Geometry comes from package constants.
- clk_i  in  1  pixel/system clock; single clock domain.
- reset_i  in  1  synchronous, active-high reset.
- char_valid_i  in  1  source has a byte.
- char_data_i  in  8 (byte_t)  byte to interpret.
- char_ready_o  out  1  registered; byte accepted on the edge where valid && ready.
- vram_we_o  out  1  registered write strobe.
- vram_waddr_o  out  12  registered write address {row, col}.
- vram_wdata_o  out  8  registered write data.
- vram_raddr_o  out  12  read address, combinational from the scroll counter; 0 outside SCROLL.
- vram_rdata_i  in  8  read data, valid one cycle after vram_raddr_o.
- cursor_row_o  out  5  current cursor row, 0..29.
- cursor_col_o  out  7  current cursor column, 0..79.

## Operation
- States: IDLE, SCROLL, CLEAR_LINE, CLEAR_ALL. char_ready_o=1 only in IDLE.
- Reset values: state IDLE, char_ready_o=0 during reset (1 from the first cycle after release), vram_we_o=0, waddr/wdata=0, cursor (0,0). Reset in any state aborts at once; partial VRAM contents are left as is.
- Bytes accepted in IDLE:
  - 0x0A LF: col←0. If row<29, row←row+1. If row=29, go to SCROLL. No write.
  - 0x0D CR: col←0. No write.
  - 0x08 BS: if col>0, col←col−1 and write 0x20 at the new col. At col=0, no-op.
  - 0x0C FF: see Configuration.
  - Any other byte is a glyph. Write it at (row,col), then col←col+1. At col=79: col←0 and advance the row as for LF (SCROLL if row=29).
- SCROLL:
  - Counter walks the source cell (r,c) from (1,0) to (29,79), column-fastest. Each cycle it drives vram_raddr_o={r,c}.
  - The returned byte is written to {r−1,c}. Exactly 2320 copy writes.
  - Then CLEAR_LINE.
- CLEAR_LINE: writes 0x20 to (29,0)…(29,79), 80 writes, then IDLE. Cursor stays (29,0).
- CLEAR_ALL: writes 0x20 to every cell (0,0)…(29,79), row-major, 2400 writes, then IDLE. Cursor (0,0).
- Cells with col 80..127 or row 30..31 are never written.
- cursor_row_o/cursor_col_o update on the accept edge; the new value is visible in cycle N+1.

## Timing
- Accept edge ends cycle N.
- Glyph or BS write: vram_we_o=1 in cycle N+1 only, carrying the pre-update cursor address (BS: the post-decrement address).
- No scroll: char_ready_o stays 1, so back-to-back accepts give one write per cycle.
- Scroll (LF at row 29, or glyph at (29,79)):
  - char_ready_o=0 from N+1. Reads are issued in cycles N+1..N+2320.
  - rdata is captured into the write registers the cycle it returns, so copy writes are visible in N+3..N+2322.
  - CLEAR_LINE writes are visible in N+2323..N+2402. char_ready_o=1 in N+2403.
  - A wrapping glyph's own write (N+1) lands before its row is copied up.
- CLEAR_ALL: writes visible in N+2..N+2401. char_ready_o=1 in N+2402.
- vram_we_o never asserts outside these windows.

## Configuration
- CONSOLE_CLEAR_EN defined: 0x0C enters CLEAR_ALL as above.
- CONSOLE_CLEAR_EN undefined: CLEAR_ALL state and logic are removed, and 0x0C is treated as an ordinary glyph.

## Structure
- Package common gains:
  - CONSOLE_COLS=80, CONSOLE_ROWS=30.
  - Control-code constants CHAR_LF, CHAR_CR, CHAR_BS, CHAR_FF, CHAR_SPACE.
  - console_state_t enum.
  - vram_addr_t (12-bit {row,col}) typedef.
- No sub-module. SCROLL, CLEAR_LINE and CLEAR_ALL share one (row,col) cell counter with column wrap at 79.

## Test plan
- Reset, then send 'A','B' back-to-back → writes {0,0}=0x41 and {0,1}=0x42 in consecutive cycles; cursor (0,2); ready never drops.
- 80 glyphs 0x30 from (0,0) → last write {0,79}; cursor (1,0); no scroll.
- Cursor (5,10): BS → write 0x20 at {5,9}, cursor (5,9). CR → cursor (5,0), no write. BS at col 0 → no write, cursor unchanged.
- Preload row r with byte r; cursor (29,3); send LF → 2320 copy writes ({r−1,c}←r), then 80 writes of 0x20 to row 29. ready low exactly N+1..N+2402; cursor (29,0). Model VRAM checked cell-by-cell.
- With CONSOLE_CLEAR_EN: FF from (12,40) → 2400 writes of 0x20, cursor (0,0), ready back at N+2402. Without the macro: FF writes 0x0C at {12,40}, cursor (12,41).
- Assert reset mid-SCROLL (cycle N+1000) → next cycle: vram_we_o=0, cursor (0,0), state IDLE; ready=1 the cycle after reset release; no further writes.
